clk_step_ctrl: RTL and testbench

Run/halt/single-step controller for the CPU core clock. Generates a one-cycle clock-enable pulse `tick` at a programmable divide ratio and gates it according to run mode. It sits between the debug/board control inputs and the CPU pipeline enable, replacing a free-running divided clock with a sequenced, enable-based one. A break request from the core stops the pulse train.

---
 rtl/clk_step_ctrl_if.sv | 30 +++
 rtl/clk_step_ctrl.sv | 149 ++++++++++++++
 tb/tb_clk_step_ctrl.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/clk_step_ctrl_if.sv
// Control/status bundle for the CPU clock run/halt/step controller.
// The master side drives commands and configuration; the slave side is the controller.
interface clk_step_ctrl_if #(
  parameter int DIV_WIDTH      = 4,
  parameter int STEP_WIDTH     = 8,
  parameter int TICK_CNT_WIDTH = 32
);
  logic                      cfg_we;
  logic [DIV_WIDTH-1:0]      cfg_div;
  logic                      cfg_ack;
  logic                      cmd_run;
  logic                      cmd_halt;
  logic                      cmd_step;
  logic [STEP_WIDTH-1:0]     step_count;
  logic                      brk;
  logic                      tick;
  logic [1:0]                state;
  logic [STEP_WIDTH-1:0]     steps_left;
  logic [TICK_CNT_WIDTH-1:0] tick_cnt;

  modport master (
    output cfg_we, cfg_div, cmd_run, cmd_halt, cmd_step, step_count, brk,
    input  cfg_ack, tick, state, steps_left, tick_cnt
  );

  modport slave (
    input  cfg_we, cfg_div, cmd_run, cmd_halt, cmd_step, step_count, brk,
    output cfg_ack, tick, state, steps_left, tick_cnt
  );
endinterface

// File: rtl/clk_step_ctrl.sv
// Run/halt/single-step controller producing a divided one-cycle clock-enable pulse
// for the CPU pipeline. Halt and break requests always win over a pending tick.
module clk_step_ctrl #(
  parameter int          DIV_WIDTH      = 4,
  parameter int unsigned DIV_DEFAULT    = 2,
  parameter int          STEP_WIDTH     = 8,
  parameter int          TICK_CNT_WIDTH = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  clk_step_ctrl_if.slave ctl
);

  typedef enum logic [1:0] {
    ST_HALT = 2'b00,
    ST_RUN  = 2'b01,
    ST_STEP = 2'b10
  } state_t;

  state_t                    state_r;
  state_t                    state_s;
  logic [DIV_WIDTH-1:0]      div_r;
  logic [DIV_WIDTH-1:0]      div_s;
  logic [DIV_WIDTH-1:0]      cnt_r;
  logic [DIV_WIDTH-1:0]      cnt_s;
  logic [STEP_WIDTH-1:0]     steps_r;
  logic [STEP_WIDTH-1:0]     steps_s;
  logic [TICK_CNT_WIDTH-1:0] tick_cnt_r;
  logic [TICK_CNT_WIDTH-1:0] tick_cnt_s;
  logic                      tick_r;
  logic                      tick_s;
  logic                      ack_r;
  logic                      ack_s;
  logic                      term_s;
  logic                      stop_s;
  logic [STEP_WIDTH-1:0]     step_load_s;

  assign term_s      = (cnt_r == div_r);
  assign stop_s      = ctl.cmd_halt | ctl.brk;
  assign step_load_s = (ctl.step_count == {STEP_WIDTH{1'b0}}) ? STEP_WIDTH'(1) : ctl.step_count;

  // Next-state, divider and counter update logic.
  always_comb begin
    state_s    = state_r;
    div_s      = div_r;
    cnt_s      = cnt_r;
    steps_s    = steps_r;
    tick_s     = 1'b0;
    ack_s      = 1'b0;
    tick_cnt_s = tick_cnt_r;

    case (state_r)
      ST_HALT: begin
        cnt_s = {DIV_WIDTH{1'b0}};
        if (stop_s) begin
          state_s = ST_HALT;
        end else if (ctl.cmd_run) begin
          state_s = ST_RUN;
        end else if (ctl.cmd_step) begin
          state_s = ST_STEP;
          steps_s = step_load_s;
        end else begin
          state_s = ST_HALT;
        end
        // Configuration is only taken when no start command shares the edge.
        if (ctl.cfg_we && !ctl.cmd_run && !ctl.cmd_step) begin
          div_s = ctl.cfg_div;
          ack_s = 1'b1;
        end else begin
          div_s = div_r;
          ack_s = 1'b0;
        end
      end

      ST_RUN: begin
        if (stop_s) begin
          state_s = ST_HALT;
          cnt_s   = {DIV_WIDTH{1'b0}};
        end else if (term_s) begin
          tick_s     = 1'b1;
          cnt_s      = {DIV_WIDTH{1'b0}};
          tick_cnt_s = tick_cnt_r + TICK_CNT_WIDTH'(1);
        end else begin
          cnt_s = cnt_r + DIV_WIDTH'(1);
        end
      end

      ST_STEP: begin
        if (stop_s) begin
          state_s = ST_HALT;
          cnt_s   = {DIV_WIDTH{1'b0}};
          steps_s = {STEP_WIDTH{1'b0}};
        end else if (ctl.cmd_run) begin
          state_s = ST_RUN;
          cnt_s   = {DIV_WIDTH{1'b0}};
          steps_s = {STEP_WIDTH{1'b0}};
        end else if (term_s) begin
          tick_s     = 1'b1;
          cnt_s      = {DIV_WIDTH{1'b0}};
          tick_cnt_s = tick_cnt_r + TICK_CNT_WIDTH'(1);
          steps_s    = steps_r - STEP_WIDTH'(1);
          // Last requested tick: leave STEP on the same edge so it lands in HALT.
          if (steps_r <= STEP_WIDTH'(1)) begin
            state_s = ST_HALT;
            steps_s = {STEP_WIDTH{1'b0}};
          end else begin
            state_s = ST_STEP;
          end
        end else begin
          cnt_s = cnt_r + DIV_WIDTH'(1);
        end
      end

      default: begin
        state_s = ST_HALT;
        cnt_s   = {DIV_WIDTH{1'b0}};
        steps_s = {STEP_WIDTH{1'b0}};
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_HALT;
      div_r      <= DIV_WIDTH'(DIV_DEFAULT);
      cnt_r      <= {DIV_WIDTH{1'b0}};
      steps_r    <= {STEP_WIDTH{1'b0}};
      tick_cnt_r <= {TICK_CNT_WIDTH{1'b0}};
      tick_r     <= 1'b0;
      ack_r      <= 1'b0;
    end else begin
      state_r    <= state_s;
      div_r      <= div_s;
      cnt_r      <= cnt_s;
      steps_r    <= steps_s;
      tick_cnt_r <= tick_cnt_s;
      tick_r     <= tick_s;
      ack_r      <= ack_s;
    end
  end

  assign ctl.tick       = tick_r;
  assign ctl.cfg_ack    = ack_r;
  assign ctl.state      = state_r;
  assign ctl.steps_left = steps_r;
  assign ctl.tick_cnt   = tick_cnt_r;

endmodule

// File: tb/tb_clk_step_ctrl.sv
// Scoreboard bench for clk_step_ctrl: a behavioural model predicts every cycle's outputs,
// a negedge monitor compares them against the DUT.
module tb_clk_step_ctrl;
  localparam int DW = 4;
  localparam int SW = 8;
  localparam int TW = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  clk_step_ctrl_if #(.DIV_WIDTH(DW), .STEP_WIDTH(SW), .TICK_CNT_WIDTH(TW)) ifc ();

  clk_step_ctrl #(
    .DIV_WIDTH(DW), .DIV_DEFAULT(2), .STEP_WIDTH(SW), .TICK_CNT_WIDTH(TW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ctl(ifc.slave)
  );

  typedef struct packed {
    logic          tick;
    logic [1:0]    state;
    logic [SW-1:0] steps;
    logic [TW-1:0] cnt;
    logic          ack;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Model: mode 0 HALT, 1 RUN, 2 STEP; age = edges spent in the current RUN/STEP visit.
  int          m_state, m_div, m_age, m_steps;
  logic [TW-1:0] m_cnt;
  bit          m_tick, m_ack;

  task automatic model_reset();
    m_state = 0; m_div = 2; m_age = 0; m_steps = 0; m_cnt = '0; m_tick = 0; m_ack = 0;
  endtask

  task automatic model_edge(input bit run, input bit halt, input bit step, input bit brk,
                            input bit we, input int sc, input int cdiv);
    m_tick = 0;
    m_ack  = 0;
    if (m_state == 0) begin
      if (!halt && !brk && run) begin
        m_state = 1; m_age = 0;
      end else if (!halt && !brk && step) begin
        m_state = 2; m_age = 0; m_steps = (sc == 0) ? 1 : sc;
      end
      if (we && !run && !step) begin
        m_div = cdiv; m_ack = 1;
      end
    end else if (halt || brk) begin
      m_state = 0; m_steps = 0;
    end else if (m_state == 2 && run) begin
      m_state = 1; m_age = 0; m_steps = 0;
    end else begin
      m_age++;
      if (m_age % (m_div + 1) == 0) begin
        m_tick = 1;
        m_cnt  = m_cnt + 32'd1;
        if (m_state == 2) begin
          m_steps--;
          if (m_steps == 0) m_state = 0;
        end
      end
    end
  endtask

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cycle(input bit run, input bit halt, input bit step, input bit brk,
                       input bit we, input int sc, input int cdiv);
    exp_t e;
    ifc.cmd_run    = run;
    ifc.cmd_halt   = halt;
    ifc.cmd_step   = step;
    ifc.brk        = brk;
    ifc.cfg_we     = we;
    ifc.step_count = SW'(sc);
    ifc.cfg_div    = DW'(cdiv);
    model_edge(run, halt, step, brk, we, sc, cdiv);
    e.tick  = m_tick;
    e.state = 2'(m_state);
    e.steps = SW'(m_steps);
    e.cnt   = m_cnt;
    e.ack   = m_ack;
    @(posedge clk);
    sb.push_back(e);
    #1;
    ifc.cmd_run = 1'b0; ifc.cmd_halt = 1'b0; ifc.cmd_step = 1'b0;
    ifc.brk = 1'b0; ifc.cfg_we = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_state"}, ifc.state, 0);
    chk({tag, "_tick"}, ifc.tick, 0);
    chk({tag, "_ack"}, ifc.cfg_ack, 0);
    chk({tag, "_steps"}, ifc.steps_left, 0);
    chk({tag, "_tick_cnt"}, ifc.tick_cnt, 0);
  endtask

  // Monitor: one expected record per clock edge, compared mid-cycle.
  always @(negedge clk) begin
    if (rst_n && sb.size() > 0) begin
      exp_t e;
      exp_t a;
      e = sb.pop_front();
      a.tick = ifc.tick; a.state = ifc.state; a.steps = ifc.steps_left;
      a.cnt = ifc.tick_cnt; a.ack = ifc.cfg_ack;
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL cycle_check t=%0t: got tick=%0b state=%0d steps=%0d cnt=%0d ack=%0b expected tick=%0b state=%0d steps=%0d cnt=%0d ack=%0b",
                 $time, a.tick, a.state, a.steps, a.cnt, a.ack,
                 e.tick, e.state, e.steps, e.cnt, e.ack);
      end
    end
  end

  initial begin
    longint saved;
    ifc.cmd_run = 1'b0; ifc.cmd_halt = 1'b0; ifc.cmd_step = 1'b0; ifc.brk = 1'b0;
    ifc.cfg_we = 1'b0; ifc.cfg_div = '0; ifc.step_count = '0;
    model_reset();
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Default divide of 2: ticks every third edge.
    cycle(1, 0, 0, 0, 0, 0, 0);
    idle(12);
    chk("run_tick_cnt", ifc.tick_cnt, 4);
    chk("run_state", ifc.state, 1);

    // Reconfigure to div 0, then an ignored write while running.
    cycle(0, 1, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 1, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0);
    idle(4);
    cycle(0, 0, 0, 0, 1, 0, 3);
    idle(3);
    chk("div0_tick", ifc.tick, 1);

    // Five steps at div 1, then a zero step count.
    cycle(0, 1, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 1, 0, 1);
    saved = ifc.tick_cnt;
    cycle(0, 0, 1, 0, 0, 5, 0);
    chk("step_load", ifc.steps_left, 5);
    idle(12);
    chk("step_ticks", ifc.tick_cnt - saved, 5);
    chk("step_done_state", ifc.state, 0);
    cycle(0, 0, 1, 0, 0, 0, 0);
    idle(4);
    chk("step0_ticks", ifc.tick_cnt - saved, 6);

    // Break, priority combinations.
    cycle(1, 0, 0, 0, 0, 0, 0);
    idle(3);
    cycle(0, 0, 0, 1, 0, 0, 0);
    idle(4);
    cycle(1, 1, 0, 1, 0, 0, 0);
    chk("prio_halt", ifc.state, 0);
    cycle(1, 0, 1, 0, 0, 3, 0);
    chk("prio_run_over_step", ifc.state, 1);

    // Break colliding with terminal count at div 2.
    cycle(0, 1, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 1, 0, 2);
    cycle(1, 0, 0, 0, 0, 0, 0);
    idle(2);
    saved = ifc.tick_cnt;
    cycle(0, 0, 0, 1, 0, 0, 0);
    chk("collide_tick", ifc.tick, 0);
    chk("collide_cnt", ifc.tick_cnt, saved);
    idle(3);

    // Asynchronous reset in the middle of a step sequence.
    cycle(0, 0, 0, 0, 1, 0, 1);
    cycle(0, 0, 1, 0, 0, 7, 0);
    idle(8);
    chk("mid_step_left", ifc.steps_left, 3);
    #1 rst_n = 1'b0;
    sb.delete();
    #1 chk_reset_outputs("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    idle(6);
    cycle(1, 0, 0, 0, 0, 0, 0);
    idle(3);
    chk("post_reset_div", ifc.tick_cnt, 1);
    cycle(0, 1, 0, 0, 0, 0, 0);

    // Randomized command traffic.
    repeat (500) begin
      int r;
      bit run, halt, step, brk, we;
      r    = $urandom_range(0, 99);
      halt = (r < 4);
      brk  = (r >= 4 && r < 8);
      run  = (r >= 8 && r < 15) || ($urandom_range(0, 49) == 0);
      step = (r >= 15 && r < 23) || ($urandom_range(0, 49) == 0);
      we   = ($urandom_range(0, 9) == 0);
      cycle(run, halt, step, brk, we, $urandom_range(0, 6), $urandom_range(0, 3));
    end

    @(negedge clk);
    #1;
    chk("sb_drain", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
